// File: rtl/cache_refill_engine.sv
// Line refill engine between the cache data array and memory: optional dirty-victim
// writeback (enabled by CACHE_WRITEBACK_EN), beat-wise line fetch, single full-line commit.
module cache_refill_engine #(
    parameter int  INDEX      = 7,
    parameter int  INDEX_WAY  = 2,
    parameter int  LINE_WIDTH = 128,
    parameter int  MEM_WIDTH  = 32,
    parameter int  ADDR_WIDTH = 32,
    localparam int OFFSET     = $clog2(LINE_WIDTH / 8),
    localparam int TAG        = ADDR_WIDTH - INDEX - OFFSET
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic                  req_dirty_i,
    input  logic [INDEX-1:0]      req_index_i,
    input  logic [INDEX_WAY-1:0]  req_way_i,
    input  logic [TAG-1:0]        req_tag_i,
    input  logic [TAG-1:0]        req_victim_tag_i,
    output logic                  done_o,
    output logic                  data_we_o,
    output logic [INDEX-1:0]      data_index_o,
    output logic [INDEX_WAY-1:0]  data_way_o,
    output logic [LINE_WIDTH-1:0] data_wdata_o,
    input  logic [LINE_WIDTH-1:0] data_rdata_i,
    output logic                  mem_req_valid_o,
    input  logic                  mem_req_ready_i,
    output logic                  mem_we_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic [MEM_WIDTH-1:0]  mem_wdata_o,
    input  logic                  mem_rvalid_i,
    input  logic [MEM_WIDTH-1:0]  mem_rdata_i
);

    localparam int BEATS   = LINE_WIDTH / MEM_WIDTH;
    localparam int BEAT_W  = $clog2(BEATS);
    localparam int BYTE_SH = $clog2(MEM_WIDTH / 8);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_CAPTURE   = 3'd1,
        S_WB_REQ    = 3'd2,
        S_FILL_REQ  = 3'd3,
        S_FILL_WAIT = 3'd4,
        S_COMMIT    = 3'd5
    } state_t;

    state_t                r_state;
    logic [BEAT_W-1:0]     r_beat;
    logic [TAG-1:0]        r_tag;
    logic                  r_req_ready;
    logic                  r_done;
    logic                  r_data_we;
    logic [INDEX-1:0]      r_data_index;
    logic [INDEX_WAY-1:0]  r_data_way;
    logic [LINE_WIDTH-1:0] r_fill;
    logic                  r_mem_req_valid;
    logic [ADDR_WIDTH-1:0] r_mem_addr;

    logic [BEAT_W-1:0]     w_beat_next;
    logic                  w_last_beat;
    logic                  w_mem_accept;
    logic [LINE_WIDTH-1:0] w_fill_merged;

`ifdef CACHE_WRITEBACK_EN
    logic [TAG-1:0]        r_victim_tag;
    logic [LINE_WIDTH-1:0] r_wb_buf;
    logic                  r_mem_we;
    logic [MEM_WIDTH-1:0]  r_mem_wdata;
    logic [MEM_WIDTH-1:0]  w_wb_word_next;
`else
    logic                  w_unused;
    assign w_unused = ^{req_dirty_i, req_victim_tag_i, data_rdata_i};
`endif

    // Beat byte address: line-aligned {tag, index} plus the beat's byte offset.
    function automatic logic [ADDR_WIDTH-1:0] beat_addr(
        input logic [TAG-1:0]    tag,
        input logic [INDEX-1:0]  idx,
        input logic [BEAT_W-1:0] beat
    );
        logic [OFFSET-1:0] off;
        off = OFFSET'(beat) << BYTE_SH;
        return {tag, idx, off};
    endfunction

    assign w_beat_next  = r_beat + BEAT_W'(1);
    assign w_last_beat  = (r_beat == BEAT_W'(BEATS - 1));
    assign w_mem_accept = r_mem_req_valid & mem_req_ready_i;

    // Fill buffer with the returning beat merged into its slot.
    always_comb begin
        w_fill_merged = r_fill;
        w_fill_merged[int'(r_beat) * MEM_WIDTH +: MEM_WIDTH] = mem_rdata_i;
    end

`ifdef CACHE_WRITEBACK_EN
    // Writeback word for the beat following the one being accepted.
    always_comb begin
        w_wb_word_next = r_wb_buf[int'(w_beat_next) * MEM_WIDTH +: MEM_WIDTH];
    end
`endif

    // Refill FSM; every output is a register loaded on entry to the state that owns it.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state         <= S_IDLE;
            r_beat          <= '0;
            r_tag           <= '0;
            r_req_ready     <= 1'b1;
            r_done          <= 1'b0;
            r_data_we       <= 1'b0;
            r_data_index    <= '0;
            r_data_way      <= '0;
            r_fill          <= '0;
            r_mem_req_valid <= 1'b0;
            r_mem_addr      <= '0;
`ifdef CACHE_WRITEBACK_EN
            r_victim_tag    <= '0;
            r_wb_buf        <= '0;
            r_mem_we        <= 1'b0;
            r_mem_wdata     <= '0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (req_valid_i && r_req_ready) begin
                        r_req_ready  <= 1'b0;
                        r_beat       <= '0;
                        r_tag        <= req_tag_i;
                        r_data_index <= req_index_i;
                        r_data_way   <= req_way_i;
`ifdef CACHE_WRITEBACK_EN
                        r_victim_tag <= req_victim_tag_i;
                        if (req_dirty_i) begin
                            r_state <= S_CAPTURE;
                        end else begin
                            r_state         <= S_FILL_REQ;
                            r_mem_req_valid <= 1'b1;
                            r_mem_we        <= 1'b0;
                            r_mem_addr      <= beat_addr(req_tag_i, req_index_i, BEAT_W'(0));
                        end
`else
                        r_state         <= S_FILL_REQ;
                        r_mem_req_valid <= 1'b1;
                        r_mem_addr      <= beat_addr(req_tag_i, req_index_i, BEAT_W'(0));
`endif
                    end
                end
`ifdef CACHE_WRITEBACK_EN
                S_CAPTURE: begin
                    r_wb_buf        <= data_rdata_i;
                    r_mem_wdata     <= data_rdata_i[MEM_WIDTH-1:0];
                    r_mem_req_valid <= 1'b1;
                    r_mem_we        <= 1'b1;
                    r_mem_addr      <= beat_addr(r_victim_tag, r_data_index, BEAT_W'(0));
                    r_state         <= S_WB_REQ;
                end
                S_WB_REQ: begin
                    if (w_mem_accept) begin
                        if (w_last_beat) begin
                            r_beat     <= '0;
                            r_mem_we   <= 1'b0;
                            r_mem_addr <= beat_addr(r_tag, r_data_index, BEAT_W'(0));
                            r_state    <= S_FILL_REQ;
                        end else begin
                            r_beat      <= w_beat_next;
                            r_mem_wdata <= w_wb_word_next;
                            r_mem_addr  <= beat_addr(r_victim_tag, r_data_index, w_beat_next);
                        end
                    end
                end
`endif
                S_FILL_REQ: begin
                    if (w_mem_accept) begin
                        r_mem_req_valid <= 1'b0;
                        r_state         <= S_FILL_WAIT;
                    end
                end
                S_FILL_WAIT: begin
                    if (mem_rvalid_i) begin
                        r_fill <= w_fill_merged;
                        if (w_last_beat) begin
                            r_beat    <= '0;
                            r_data_we <= 1'b1;
                            r_done    <= 1'b1;
                            r_state   <= S_COMMIT;
                        end else begin
                            r_beat          <= w_beat_next;
                            r_mem_req_valid <= 1'b1;
                            r_mem_addr      <= beat_addr(r_tag, r_data_index, w_beat_next);
                            r_state         <= S_FILL_REQ;
                        end
                    end
                end
                S_COMMIT: begin
                    r_data_we   <= 1'b0;
                    r_done      <= 1'b0;
                    r_req_ready <= 1'b1;
                    r_state     <= S_IDLE;
                end
                default: begin
                    r_state         <= S_IDLE;
                    r_beat          <= '0;
                    r_req_ready     <= 1'b1;
                    r_done          <= 1'b0;
                    r_data_we       <= 1'b0;
                    r_mem_req_valid <= 1'b0;
                end
            endcase
        end
    end

    assign req_ready_o     = r_req_ready;
    assign done_o          = r_done;
    assign data_we_o       = r_data_we;
    assign data_index_o    = r_data_index;
    assign data_way_o      = r_data_way;
    assign data_wdata_o    = r_fill;
    assign mem_req_valid_o = r_mem_req_valid;
    assign mem_addr_o      = r_mem_addr;
`ifdef CACHE_WRITEBACK_EN
    assign mem_we_o        = r_mem_we;
    assign mem_wdata_o     = r_mem_wdata;
`else
    assign mem_we_o        = 1'b0;
    assign mem_wdata_o     = MEM_WIDTH'(0);
`endif

endmodule

// File: tb/tb_cache_refill_engine.sv
// Self-checking bench for cache_refill_engine: directed scenarios plus randomized misses
// against a memory/array model with random stalls, delayed and spurious read data.
module tb_cache_refill_engine;

    localparam int INDEX = 7, WAYW = 2, LW = 128, MW = 32, AW = 32;
    localparam int OFF = 4, TAGW = AW - INDEX - OFF, BEATS = LW / MW;
`ifdef CACHE_WRITEBACK_EN
    localparam bit WB = 1'b1;
`else
    localparam bit WB = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_i;
    logic req_valid_i, req_ready_o, req_dirty_i;
    logic [INDEX-1:0] req_index_i;
    logic [WAYW-1:0] req_way_i;
    logic [TAGW-1:0] req_tag_i, req_victim_tag_i;
    logic done_o, data_we_o;
    logic [INDEX-1:0] data_index_o;
    logic [WAYW-1:0] data_way_o;
    logic [LW-1:0] data_wdata_o, data_rdata_i;
    logic mem_req_valid_o, mem_req_ready_i, mem_we_o;
    logic [AW-1:0] mem_addr_o;
    logic [MW-1:0] mem_wdata_o, mem_rdata_i;
    logic mem_rvalid_i;

    logic [LW-1:0] arr [0:(1<<INDEX)-1][0:(1<<WAYW)-1];
    assign data_rdata_i = arr[data_index_o][data_way_o];

    always #5 clk = ~clk;

    cache_refill_engine dut (
        .clk_i(clk), .rst_i(rst_i),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_dirty_i(req_dirty_i),
        .req_index_i(req_index_i), .req_way_i(req_way_i), .req_tag_i(req_tag_i),
        .req_victim_tag_i(req_victim_tag_i), .done_o(done_o), .data_we_o(data_we_o),
        .data_index_o(data_index_o), .data_way_o(data_way_o), .data_wdata_o(data_wdata_o),
        .data_rdata_i(data_rdata_i), .mem_req_valid_o(mem_req_valid_o),
        .mem_req_ready_i(mem_req_ready_i), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
        .mem_wdata_o(mem_wdata_o), .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i)
    );

    // Memory-model knobs, written only by the main sequence.
    bit cfg_rand, cfg_directed, cfg_spur;
    int cfg_rdelay, cfg_stall_beat, cfg_stall_n;
    int flush_req = 0;

    // Memory-model logs, written only by the responder.
    logic [AW-1:0] wr_addr [0:1023];
    logic [MW-1:0] wr_data [0:1023];
    logic [AW-1:0] rd_addr [0:1023];
    logic [MW-1:0] rd_word [0:1023];
    int wr_n = 0, rd_n = 0, n_stall = 0, stab_err = 0, we_hi_n = 0;

    int n_vec = 0, n_mis = 0;

    task automatic chk(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [AW-1:0] exp_addr(input int tag, input int idx, input int beat);
        return AW'(tag * 2048 + idx * 16 + beat * 4);
    endfunction

    // Memory responder: acts at each negedge for the cycle that follows.
    initial begin
        bit in_req = 1'b0, rd_pend = 1'b0;
        int stall_left = 0, rd_cnt = 0, flush_seen = 0;
        logic [AW-1:0] h_addr;
        logic [MW-1:0] h_data, pend_word, w;
        logic h_we;
        mem_req_ready_i = 1'b1; mem_rvalid_i = 1'b0; mem_rdata_i = '0;
        forever begin
            @(negedge clk);
            if (flush_seen != flush_req) begin
                flush_seen = flush_req; rd_pend = 1'b0; in_req = 1'b0; stall_left = 0;
            end
            if (mem_we_o === 1'b1) we_hi_n++;
            mem_rvalid_i = 1'b0;
            if (rd_pend) begin
                if (rd_cnt == 0) begin
                    mem_rvalid_i = 1'b1; mem_rdata_i = pend_word; rd_pend = 1'b0;
                end else begin
                    rd_cnt--; n_stall++;
                end
            end else if (cfg_spur && mem_req_valid_o && !mem_we_o) begin
                mem_rvalid_i = 1'b1; mem_rdata_i = 32'hDEAD_BEEF;
            end
            if (mem_req_valid_o === 1'b1) begin
                if (!in_req) begin
                    in_req = 1'b1; h_addr = mem_addr_o; h_we = mem_we_o; h_data = mem_wdata_o;
                    if (cfg_rand)
                        stall_left = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
                    else if (!mem_we_o && int'(mem_addr_o[3:2]) == cfg_stall_beat)
                        stall_left = cfg_stall_n;
                    else
                        stall_left = 0;
                end else if (mem_addr_o !== h_addr || mem_we_o !== h_we ||
                             (h_we && mem_wdata_o !== h_data)) begin
                    stab_err++;
                end
                if (stall_left > 0) begin
                    mem_req_ready_i = 1'b0; stall_left--; n_stall++;
                end else begin
                    mem_req_ready_i = 1'b1; in_req = 1'b0;
                    if (mem_we_o) begin
                        wr_addr[wr_n] = mem_addr_o; wr_data[wr_n] = mem_wdata_o; wr_n++;
                    end else begin
                        w = cfg_directed ? (32'hA0 + {30'd0, mem_addr_o[3:2]}) : MW'($urandom);
                        rd_addr[rd_n] = mem_addr_o; rd_word[rd_n] = w; rd_n++;
                        pend_word = w; rd_pend = 1'b1;
                        rd_cnt = cfg_rand ? $urandom_range(0, 3) : cfg_rdelay;
                    end
                end
            end else begin
                in_req = 1'b0;
                mem_req_ready_i = 1'($urandom_range(0, 1));
            end
        end
    end

    task automatic send_req(input int idx, input int way, input int tag, input int vtag, input bit dirty);
        @(negedge clk); #1;
        chk("ready_idle", LW'(req_ready_o), LW'(1));
        req_valid_i = 1'b1; req_dirty_i = dirty;
        req_index_i = INDEX'(idx); req_way_i = WAYW'(way);
        req_tag_i = TAGW'(tag); req_victim_tag_i = TAGW'(vtag);
        @(posedge clk); #1;
        req_valid_i = 1'b0; req_dirty_i = 1'($urandom);
        req_index_i = INDEX'($urandom); req_way_i = WAYW'($urandom);
        req_tag_i = TAGW'($urandom); req_victim_tag_i = TAGW'($urandom);
    endtask

    task automatic run_txn(input int idx, input int way, input int tag, input int vtag,
                           input bit dirty, output int done_cyc, output logic [LW-1:0] line);
        int wr0, rd0, st0, cyc, n_we, exp_cyc;
        bit exp_wb;
        logic [LW-1:0] pre_line, c_line, exp_line;
        logic [INDEX-1:0] c_idx;
        logic [WAYW-1:0] c_way;
        wr0 = wr_n; rd0 = rd_n; st0 = n_stall;
        pre_line = arr[idx][way];
        c_line = '0; c_idx = '0; c_way = '0;
        send_req(idx, way, tag, vtag, dirty);
        cyc = 0; n_we = 0; done_cyc = -1;
        while (done_cyc < 0 && cyc < 400) begin
            @(negedge clk); #1; cyc++;
            if (data_we_o) begin
                n_we++; c_idx = data_index_o; c_way = data_way_o; c_line = data_wdata_o;
            end
            if (done_o) done_cyc = cyc;
        end
        @(negedge clk); #1;
        chk("ready_after_commit", LW'(req_ready_o), LW'(1));
        chk("done_one_cycle", LW'(done_o), LW'(0));
        chk("we_one_cycle", LW'(data_we_o), LW'(0));
        exp_wb = WB && dirty;
        exp_cyc = (exp_wb ? 2 + 3 * BEATS : 1 + 2 * BEATS) + (n_stall - st0);
        chk("done_cycle", LW'(done_cyc), LW'(exp_cyc));
        chk("wr_beats", LW'(wr_n - wr0), LW'(exp_wb ? BEATS : 0));
        for (int b = 0; b < BEATS && exp_wb; b++) begin
            chk($sformatf("wr_addr%0d", b), LW'(wr_addr[wr0 + b]), LW'(exp_addr(vtag, idx, b)));
            chk($sformatf("wr_data%0d", b), LW'(wr_data[wr0 + b]), LW'(pre_line[b * MW +: MW]));
        end
        chk("rd_beats", LW'(rd_n - rd0), LW'(BEATS));
        exp_line = '0;
        for (int b = 0; b < BEATS; b++) begin
            chk($sformatf("rd_addr%0d", b), LW'(rd_addr[rd0 + b]), LW'(exp_addr(tag, idx, b)));
            exp_line[b * MW +: MW] = rd_word[rd0 + b];
        end
        chk("array_writes", LW'(n_we), LW'(1));
        chk("commit_index", LW'(c_idx), LW'(idx));
        chk("commit_way", LW'(c_way), LW'(way));
        chk("commit_line", c_line, exp_line);
        chk("addr_data_stable", LW'(stab_err), LW'(0));
        if (!WB) chk("mem_we_never", LW'(we_hi_n), LW'(0));
        arr[idx][way] = exp_line;
        line = c_line;
    endtask

    initial begin
        int dc, rd0, n_we;
        logic [LW-1:0] line;
        bit hit;
        for (int i = 0; i < (1 << INDEX); i++)
            for (int j = 0; j < (1 << WAYW); j++)
                arr[i][j] = {$urandom, $urandom, $urandom, $urandom};
        cfg_rand = 1'b0; cfg_directed = 1'b0; cfg_spur = 1'b0;
        cfg_rdelay = 0; cfg_stall_beat = -1; cfg_stall_n = 0;
        rst_i = 1'b1; req_valid_i = 1'b0; req_dirty_i = 1'b0;
        req_index_i = '0; req_way_i = '0; req_tag_i = '0; req_victim_tag_i = '0;

        // Reset values, during and after reset.
        @(posedge clk); #1;
        chk("rst_ready", LW'(req_ready_o), LW'(1));
        chk("rst_outs", LW'({done_o, data_we_o, mem_req_valid_o, mem_we_o}), LW'(0));
        chk("rst_addr", LW'(mem_addr_o), LW'(0));
        chk("rst_index_way", LW'({data_index_o, data_way_o}), LW'(0));
        chk("rst_wdata", LW'({data_wdata_o, mem_wdata_o}), LW'(0));
        @(posedge clk); #1 rst_i = 1'b0;
        @(posedge clk); #1;
        chk("post_rst_ready", LW'(req_ready_o), LW'(1));
        chk("post_rst_valid", LW'(mem_req_valid_o), LW'(0));

        // Clean miss with known memory data.
        cfg_directed = 1'b1;
        run_txn(5, 2, 'h1234, 'h0, 1'b0, dc, line);
        chk("clean_done9", LW'(dc), LW'(9));
        chk("clean_line", line, 128'h000000A3_000000A2_000000A1_000000A0);

        // Dirty miss with a known victim line.
        arr[3][1] = 128'h44444444_33333333_22222222_11111111;
        run_txn(3, 1, 'h55, 'h77, 1'b1, dc, line);
        chk("dirty_done", LW'(dc), LW'(WB ? 14 : 9));

        // Ready held low three cycles on fill beat 1.
        cfg_stall_beat = 1; cfg_stall_n = 3;
        run_txn(7, 0, 'h2222, 'h0, 1'b0, dc, line);
        chk("stall_done12", LW'(dc), LW'(12));
        cfg_stall_beat = -1;

        // Read data delayed five cycles, spurious rvalid while requesting.
        cfg_rdelay = 5; cfg_spur = 1'b1;
        run_txn(9, 3, 'h0BEE, 'h0, 1'b0, dc, line);
        chk("rdelay_done29", LW'(dc), LW'(29));
        chk("rdelay_line", line, 128'h000000A3_000000A2_000000A1_000000A0);

        // Reset while waiting for fill beat 2.
        cfg_rdelay = 3; cfg_spur = 1'b0; cfg_directed = 1'b0;
        rd0 = rd_n;
        send_req(11, 1, 'h3333, 'h0, 1'b0);
        hit = 1'b0;
        for (int k = 0; k < 200 && !hit; k++) begin
            @(posedge clk); #1;
            if (rd_n - rd0 == 3) hit = 1'b1;
        end
        chk("reached_fill_wait2", LW'(hit), LW'(1));
        rst_i = 1'b1; flush_req++;
        @(posedge clk); #1 rst_i = 1'b0;
        chk("abort_ready", LW'(req_ready_o), LW'(1));
        chk("abort_outs", LW'({done_o, data_we_o, mem_req_valid_o}), LW'(0));
        chk("abort_addr", LW'(mem_addr_o), LW'(0));
        n_we = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk); #1;
            if (data_we_o) n_we++;
        end
        chk("abort_no_write", LW'(n_we), LW'(0));
        cfg_rdelay = 0;
        run_txn(11, 1, 'h3344, 'h0, 1'b0, dc, line);

        // Randomized misses with random stalls, read latency and spurious rvalid.
        cfg_rand = 1'b1;
        for (int t = 0; t < 14; t++) begin
            cfg_spur = 1'($urandom);
            run_txn($urandom_range(0, (1 << INDEX) - 1), $urandom_range(0, (1 << WAYW) - 1),
                    $urandom_range(0, (1 << TAGW) - 1), $urandom_range(0, (1 << TAGW) - 1),
                    1'($urandom), dc, line);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
